seq_stream_ctrl: RTL and testbench
==================================

# seq_stream_ctrl

Controller that runs a serial bit-pattern detector over a burst of parallel words. Software-side logic issues `start` with a 4-bit pattern and a word count. The block then accepts that many words over a valid/ready port and shifts each word MSB-first into the detector, one bit per clock. It counts detector matches, emits a per-match pulse, and signals `done` with the final count.

## Interface
- `DATA_W`, default 8: input word width; also the number of shift cycles per word.
- `CNT_W`, default 8: match counter width; also the width of `len`.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a burst; honoured only in IDLE.
- `pattern`  in  4: target sequence, bit 3 first; sampled on the accepted `start`.
- `len`  in  CNT_W: number of words in the burst; sampled on the accepted `start`.
- `in_valid`  in  1: upstream word valid.
- `in_data`  in  DATA_W: upstream word.
- `in_ready`  out  1: high only in WAIT.
- `busy`  out  1: state != IDLE.
- `match_pulse`  out  1: registered one-cycle pulse per detected match.
- `match_count`  out  CNT_W: matches in the current or last burst; saturating.
- `done`  out  1: one-cycle pulse at burst end.

## Operation
- FSM states:
  - IDLE: a `start` latches `pattern` and `len`, clears `match_count`, and clears the detector history. The FSM then goes to WAIT, or to DONE if `len == 0`.
  - WAIT: `in_ready = 1`. On `in_valid && in_ready`, the word is latched into the shift register and the FSM goes to SHIFT. With `in_valid` low, the FSM stays in WAIT and the history is retained.
  - SHIFT: presents one bit per cycle, MSB first, for exactly DATA_W cycles. After the last bit, the words-remaining counter decrements. The FSM goes to WAIT if words remain, otherwise to DONE.
  - DONE: `done = 1` for one cycle, then the FSM goes to IDLE.
- Detector, sub-module:
  - Holds the last 3 bits plus a fill count from 0 to 3.
  - Mealy match is combinational: `{hist[2:0], bit} == pattern` and fill count == 3.
  - Fill count increments per bit, saturating at 3.
- The bit stream is continuous across words. History is never cleared between words of a burst, so matches may span word boundaries.
- On a match, `match_pulse` and `match_count` update at the clock edge that consumes the completing bit.
- `match_count` saturates at 2^CNT_W − 1 and holds its value from DONE until the next accepted `start`.
- `start` is ignored while `busy`.
- Asynchronous reset at any point, including mid-SHIFT, forces:
  - state IDLE and `busy` 0;
  - `in_ready` 0, `done` 0, `match_pulse` 0;
  - `match_count` 0;
  - history and fill count 0, latched pattern 0, words remaining 0.
  - No partial burst resumes after reset.

## Timing
- Start to `in_ready`: `start` is sampled at edge E, and `in_ready` is high in the cycle after E.
- Word throughput: at best DATA_W + 1 cycles per word (1 WAIT cycle + DATA_W SHIFT cycles).
- Best-case burst length: `len` × (DATA_W + 1) cycles after the start edge, followed by 1 DONE cycle.
- Match latency: `match_pulse` is high in the cycle after the completing bit is presented.
- A match on the final bit of a burst pulses in the DONE cycle and is included in `match_count` when `done` is high.
- `len == 0`: `done` pulses in the cycle after start, `match_count` is 0, and `in_ready` never asserts.

## Configuration
- `SEQ_OVERLAP_EN` defined: overlapping detection. History and fill count are kept after a match, so the match suffix can begin the next match.
- `SEQ_OVERLAP_EN` undefined: non-overlapping detection. The completing bit is consumed and fill count returns to 0 after a match, so the next match needs 4 fresh bits.

## Structure
- Package `seq_ctrl_pkg`:
  - state enum (IDLE, WAIT, SHIFT, DONE);
  - `PAT_W = 4`.
- Sub-module `seq_pattern_det`:
  - ports: clk, rst_n, clr, bit_valid, bit_in, pattern;
  - output: combinational match;
  - the only place `SEQ_OVERLAP_EN` is tested.
- Controller top module holds the FSM, the shift register, the words-remaining counter and the match counter.

## Test plan
- Single word: pattern 4'b1010, len 1, word 8'hAA → 3 matches with `SEQ_OVERLAP_EN`, 2 without. Pulses occur the cycle after bits 4, 6, 8 (overlap) or bits 4, 8 (non-overlap).
- Cross-word match: pattern 4'b1010, len 2, words 8'h01 then 8'h40 → exactly 1 match, on bit 11 of the stream.
- Zero length: `len` 0 → `done` in the cycle after start, `match_count` 0, `in_ready` never high.
- Backpressure: `in_valid` held low 5 cycles between the two words of the cross-word case → same single match, history retained; `start` pulses while busy are ignored.
- Reset mid-SHIFT: `rst_n` low during bit 3 of a word → all outputs reset immediately. A fresh burst (pattern 4'b1010, len 1, 8'hAA) then yields the normal count.
- Saturation: overlap build, pattern 4'b0000, len 70, all words 8'h00 → `match_count` saturates at 255, and `match_pulse` continues pulsing until DONE.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// Shared types for the stream pattern-detect controller.
// Build option SEQ_OVERLAP_EN is consumed by seq_pattern_det only.
package seq_ctrl_pkg;

  localparam int PAT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/seq_pattern_det.sv
// Serial 4-bit pattern detector with a fill counter so stale history never matches.
// SEQ_OVERLAP_EN defined: history survives a match; undefined: a match restarts the fill.
module seq_pattern_det
  import seq_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             match
);

  logic [PAT_W-2:0] hist_q, hist_d;
  logic [1:0]       fill_q, fill_d;

  always_comb begin
    match  = bit_valid && (fill_q == 2'd3) && ({hist_q, bit_in} == pattern);
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (bit_valid) begin
      hist_d = {hist_q[PAT_W-3:0], bit_in};
      fill_d = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
`ifdef SEQ_OVERLAP_EN
      fill_d = fill_d;
`else
      // completing bit is consumed: next match needs four fresh bits
      if (match) fill_d = 2'd0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_stream_ctrl.sv
// Burst controller: accepts len words, shifts them MSB-first into seq_pattern_det, counts matches.
// Detection mode follows SEQ_OVERLAP_EN (see seq_pattern_det).
//
//   state | meaning
//   IDLE  | waiting for start; match_count holds last result
//   WAIT  | in_ready high, waiting for the next word
//   SHIFT | presenting one bit per cycle, DATA_W cycles
//   DONE  | one-cycle done pulse
module seq_stream_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PAT_W-1:0]  pattern,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_count,
  output logic              done
);

  localparam int BC_W = $clog2(DATA_W + 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic              pulse_q, pulse_d;
  logic              det_clr, det_valid, det_match;

  seq_pattern_det u_det (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (det_clr),
    .bit_valid (det_valid),
    .bit_in    (shreg_q[DATA_W-1]),
    .pattern   (pat_q),
    .match     (det_match)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    words_d   = words_q;
    count_d   = count_q;
    pat_d     = pat_q;
    pulse_d   = 1'b0;
    det_clr   = 1'b0;
    det_valid = (state_q == SHIFT);
    case (state_q)
      IDLE: if (start) begin
        pat_d   = pattern;
        words_d = len;
        count_d = '0;
        det_clr = 1'b1;
        state_d = (len == '0) ? DONE : WAIT;
      end
      WAIT: if (in_valid) begin
        shreg_d   = in_data;
        bit_cnt_d = BC_W'(DATA_W - 1);
        state_d   = SHIFT;
      end
      SHIFT: begin
        shreg_d = shreg_q << 1;
        if (bit_cnt_q == '0) begin
          words_d = words_q - CNT_W'(1);
          state_d = (words_q == CNT_W'(1)) ? DONE : WAIT;
        end else begin
          bit_cnt_d = bit_cnt_q - BC_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // match is only ever asserted in SHIFT, so the counter updates on the consuming edge
    if (det_match) begin
      pulse_d = 1'b1;
      if (count_q != '1) count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      words_q   <= '0;
      count_q   <= '0;
      pat_q     <= '0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      words_q   <= words_d;
      count_q   <= count_d;
      pat_q     <= pat_d;
      pulse_q   <= pulse_d;
    end
  end

  assign in_ready    = (state_q == WAIT);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign match_pulse = pulse_q;
  assign match_count = count_q;

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Randomized and directed bench for seq_stream_ctrl against a bit-stream reference model.
// Honours SEQ_OVERLAP_EN the same way as the design build.
`timescale 1ns/1ps
module tb_seq_stream_ctrl;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;
`ifdef SEQ_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [3:0]        pattern = '0;
  logic [CNT_W-1:0]  len = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready, busy, match_pulse, done;
  logic [CNT_W-1:0]  match_count;

  seq_stream_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pattern     (pattern),
    .len         (len),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .busy        (busy),
    .match_pulse (match_pulse),
    .match_count (match_count),
    .done        (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 awaiting word, 2 shifting, 3 done.
  int         m_phase, m_words, m_bits, m_last, m_cnt;
  bit         m_pulse;
  logic [7:0] m_word;
  logic [3:0] m_pat;
  bit         m_stream[$];
  int         m_pos[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_words = 0; m_bits = 0; m_last = 0; m_cnt = 0;
      m_pulse = 0; m_word = '0; m_pat = '0;
      m_stream.delete(); m_pos.delete();
    end else begin
      m_pulse = 0;
      case (m_phase)
        0: if (start) begin
          m_pat = pattern; m_words = int'(len); m_cnt = 0; m_last = 0;
          m_stream.delete(); m_pos.delete();
          m_phase = (len == 0) ? 3 : 1;
        end
        1: if (in_valid) begin
          m_word = in_data; m_bits = DATA_W; m_phase = 2;
        end
        2: begin
          int k;
          m_stream.push_back(m_word[m_bits-1]);
          k = m_stream.size() - 1;
          if (k - m_last >= 3 &&
              {m_stream[k-3], m_stream[k-2], m_stream[k-1], m_stream[k]} == m_pat) begin
            m_pulse = 1;
            m_pos.push_back(k + 1);
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (!OVL) m_last = k + 1;
          end
          m_bits--;
          if (m_bits == 0) begin
            m_words--;
            m_phase = (m_words > 0) ? 1 : 3;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy",        busy,        32'(m_phase != 0));
      chk("in_ready",    in_ready,    32'(m_phase == 1));
      chk("done",        done,        32'(m_phase == 3));
      chk("match_pulse", match_pulse, 32'(m_pulse));
      chk("match_count", match_count, 32'(m_cnt));
    end
  end

  logic [7:0] wq[$];
  int         gq[$];

  task automatic do_start(input logic [3:0] p, input int n, output int e_cyc);
    start = 1'b1; pattern = p; len = n[CNT_W-1:0];
    @(posedge clk); #1;
    e_cyc = cyc;
    start = 1'b0; pattern = 4'($urandom); len = 8'($urandom);
  endtask

  task automatic send_word(input logic [7:0] w, input int gap, input bit spam);
    bit ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    for (int g = 0; g < gap; g++) begin
      start = spam && (g == 1); pattern = 4'($urandom); len = 8'($urandom_range(1, 3));
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid = 1'b1; in_data = w;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 8'($urandom);
  endtask

  task automatic wait_done(output int d_cyc);
    bit ok = 0;
    d_cyc = -1;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; d_cyc = cyc; end
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  task automatic run_burst(input logic [3:0] p, input int n, input bit spam,
                           output int lat, output int cnt);
    int e, d;
    @(posedge clk); #1;
    do_start(p, n, e);
    for (int i = 0; i < n; i++) send_word(wq[i], gq[i], spam);
    wait_done(d);
    lat = d - e;
    cnt = int'(match_count);
  endtask

  initial begin
    int lat, cnt, n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_pulse", match_pulse, 0);
    chk("rst_count", match_count, 0);
    @(negedge clk); #2 rst_n = 1'b1;

    // single word
    wq = '{8'hAA}; gq = '{0};
    run_burst(4'b1010, 1, 0, lat, cnt);
    chk("single_count", cnt, OVL ? 3 : 2);
    chk("single_lat", lat, 9);
    chk("single_npos", m_pos.size(), OVL ? 3 : 2);
    chk("single_pos0", m_pos[0], 4);
    chk("single_pos1", m_pos[1], OVL ? 6 : 8);
    chk("single_poslast", m_pos[m_pos.size()-1], 8);

    // cross-word match
    wq = '{8'h01, 8'h40}; gq = '{0, 0};
    run_burst(4'b1010, 2, 0, lat, cnt);
    chk("cross_count", cnt, 1);
    chk("cross_lat", lat, 18);
    chk("cross_pos", m_pos[0], 11);

    // zero length
    run_burst(4'b1010, 0, 0, lat, cnt);
    chk("zero_lat", lat, 0);
    chk("zero_count", cnt, 0);
    chk("zero_model", m_cnt, 0);

    // backpressure with start spam while busy
    wq = '{8'h01, 8'h40}; gq = '{0, 5};
    run_burst(4'b1010, 2, 1, lat, cnt);
    chk("bp_count", cnt, 1);
    chk("bp_lat", lat, 23);
    chk("bp_npos", m_pos.size(), 1);
    chk("bp_pos", m_pos[0], 11);

    // reset during bit 3 of a word
    begin
      int e;
      @(posedge clk); #1;
      do_start(4'b1010, 1, e);
      send_word(8'hAA, 0, 0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_pulse", match_pulse, 0);
      chk("mid_rst_count", match_count, 0);
      @(negedge clk); #2 rst_n = 1'b1;
    end
    wq = '{8'hAA}; gq = '{0};
    run_burst(4'b1010, 1, 0, lat, cnt);
    chk("post_rst_count", cnt, OVL ? 3 : 2);

    // saturation
    wq.delete(); gq.delete();
    for (int i = 0; i < 70; i++) begin wq.push_back(8'h00); gq.push_back(0); end
    run_burst(4'b0000, 70, 0, lat, cnt);
    chk("sat_count", cnt, OVL ? 255 : 140);
    chk("sat_model_matches", m_pos.size(), OVL ? 557 : 140);

    // randomized bursts
    for (int b = 0; b < 25; b++) begin
      n = $urandom_range(0, 5);
      wq.delete(); gq.delete();
      for (int i = 0; i < n; i++) begin
        wq.push_back(8'($urandom));
        gq.push_back($urandom_range(0, 3));
      end
      run_burst(4'($urandom), n, 1'($urandom), lat, cnt);
      chk("rand_count", cnt, m_cnt);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
